// File: rtl/arith_encoder_result_checker.sv
// Self-checking result comparator: delays expected range/low by PIPE_LATENCY cycles,
// compares against encoder outputs, and accumulates pass/fail statistics per stream.
module arith_encoder_result_checker #(
    parameter int RANGE_WIDTH  = 16,
    parameter int LOW_WIDTH    = 24,
    parameter int PIPE_LATENCY = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   general_clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   exp_valid,
    input  logic                   exp_last,
    input  logic [RANGE_WIDTH-1:0] exp_range,
    input  logic [LOW_WIDTH-1:0]   exp_low,
    input  logic                   check_low_en,
    input  logic [RANGE_WIDTH-1:0] dut_range,
    input  logic [LOW_WIDTH-1:0]   dut_low,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_WIDTH-1:0]   vec_count,
    output logic [CNT_WIDTH-1:0]   err_count,
    output logic                   err_pulse,
    output logic                   err_range_flag,
    output logic                   err_low_flag,
    output logic                   first_err_valid,
    output logic [CNT_WIDTH-1:0]   first_err_idx
);

    localparam int unsigned TAIL = PIPE_LATENCY - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state;

    logic [PIPE_LATENCY-1:0] st_valid;
    logic [PIPE_LATENCY-1:0] st_last;
    logic [PIPE_LATENCY-1:0] st_low_en;
    logic [RANGE_WIDTH-1:0]  st_range [PIPE_LATENCY];
    logic [LOW_WIDTH-1:0]    st_low   [PIPE_LATENCY];
    logic [CNT_WIDTH-1:0]    st_idx   [PIPE_LATENCY];
    logic [CNT_WIDTH-1:0]    push_count;

    logic push, cmp, range_diff, low_diff, mismatch;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_comb begin
        push       = exp_valid && (state == IDLE || state == RUN);
        cmp        = st_valid[TAIL];
        range_diff = st_range[TAIL] != dut_range;
        low_diff   = st_low_en[TAIL] && (st_low[TAIL] != dut_low);
        mismatch   = cmp && (range_diff || low_diff);
    end

    always_ff @(posedge general_clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            st_valid        <= '0;
            st_last         <= '0;
            st_low_en       <= '0;
            for (int unsigned i = 0; i < PIPE_LATENCY; i++) begin
                st_range[i] <= '0;
                st_low[i]   <= '0;
                st_idx[i]   <= '0;
            end
            push_count      <= '0;
            vec_count       <= '0;
            err_count       <= '0;
            err_pulse       <= 1'b0;
            err_range_flag  <= 1'b0;
            err_low_flag    <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else if (clear) begin
            // Pending compares are dropped by invalidating every stage.
            state           <= IDLE;
            st_valid        <= '0;
            push_count      <= '0;
            vec_count       <= '0;
            err_count       <= '0;
            err_pulse       <= 1'b0;
            err_range_flag  <= 1'b0;
            err_low_flag    <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else begin
            st_valid[0]  <= push;
            st_last[0]   <= exp_last;
            st_low_en[0] <= check_low_en;
            st_range[0]  <= exp_range;
            st_low[0]    <= exp_low;
            st_idx[0]    <= push_count;
            for (int unsigned i = 1; i < PIPE_LATENCY; i++) begin
                st_valid[i]  <= st_valid[i-1];
                st_last[i]   <= st_last[i-1];
                st_low_en[i] <= st_low_en[i-1];
                st_range[i]  <= st_range[i-1];
                st_low[i]    <= st_low[i-1];
                st_idx[i]    <= st_idx[i-1];
            end
            if (push) push_count <= sat_inc(push_count);

            err_pulse <= mismatch;
            if (cmp) vec_count <= sat_inc(vec_count);
            if (mismatch) begin
                err_count      <= sat_inc(err_count);
                err_range_flag <= range_diff;
                err_low_flag   <= low_diff;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_idx   <= st_idx[TAIL];
                end
            end

            case (state)
                IDLE:    if (push) state <= exp_last ? DRAIN : RUN;
                RUN:     if (push && exp_last) state <= DRAIN;
                DRAIN:   if (cmp && st_last[TAIL]) state <= DONE;
                default: state <= state;
            endcase
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_count == '0);

endmodule

// File: doc/arith_encoder_result_checker.md
Name: arith_encoder_result_checker

Overview:
- Parametrised, self-checking result comparator for the arithmetic encoder verification flow.
- Holds expected range/low values for each applied stimulus vector in a delay line of depth PIPE_LATENCY.
- Compares each held pair against the encoder RANGE_OUTPUT/LOW_OUTPUT exactly PIPE_LATENCY cycles later.
- Counts vectors and mismatches, logs the first failing index, and reports pass/fail at stream end. It replaces hand-coded fixed-offset comparisons in per-file benches.

Parameters:
- RANGE_WIDTH, 16, width of expected and DUT range.
- LOW_WIDTH, 24, width of expected and DUT low.
- PIPE_LATENCY, 3, encoder input-to-output latency in cycles; legal range 1..16.
- CNT_WIDTH, 16, width of vector/error counters and index.

Ports:
- general_clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  synchronous: flush delay line, zero counters, state to IDLE.
- exp_valid  in  1  expected vector present; asserted in the same cycle the matching stimulus is applied to the encoder.
- exp_last  in  1  qualifies exp_valid; marks the final vector of the stream.
- exp_range  in  RANGE_WIDTH  expected range.
- exp_low  in  LOW_WIDTH  expected low.
- check_low_en  in  1  1: compare range and low; 0: compare range only. Sampled at push time and stored per entry.
- dut_range  in  RANGE_WIDTH  encoder RANGE_OUTPUT.
- dut_low  in  LOW_WIDTH  encoder LOW_OUTPUT.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- pass  out  1  done and err_count==0.
- vec_count  out  CNT_WIDTH  compared vectors, saturating.
- err_count  out  CNT_WIDTH  mismatched vectors, saturating.
- err_pulse  out  1  one-cycle pulse per mismatch.
- err_range_flag  out  1  range differed on the last mismatch (valid with err_pulse).
- err_low_flag  out  1  low differed on the last mismatch (valid with err_pulse).
- first_err_valid  out  1  sticky; a mismatch has been logged.
- first_err_idx  out  CNT_WIDTH  vector index of the first mismatch.

Behaviour:
- Reset: all outputs 0, delay line invalid, state IDLE.
- Delay line: PIPE_LATENCY stages. Each stage holds {valid, last, low_en, exp_range, exp_low, idx}.
  - Stage 0 loads the inputs at each edge.
  - idx = push counter, incremented per accepted push, saturating.
  - exp_valid=0 inserts a bubble (valid=0). Bubbles are never compared.
- Compare rule:
  - An entry pushed at edge k is compared at edge k+PIPE_LATENCY against dut_range/dut_low sampled at that edge.
  - Mismatch = (range differs) OR (low_en AND low differs).
  - Results register at that edge: vec_count+1; on mismatch also err_count+1, err_pulse=1 for one cycle, and the range/low flags set.
  - First mismatch only: first_err_idx=idx, first_err_valid=1.
- State machine:
  - IDLE → RUN on the first exp_valid push.
  - RUN → DRAIN on a push with exp_last=1.
  - DRAIN → DONE at the edge where the entry flagged last is compared. That compare is still counted.
  - DONE holds all results until clear or reset.
- Pushes are accepted only in IDLE and RUN; exp_valid in DRAIN or DONE is ignored.
- exp_last without exp_valid is ignored.
- Simultaneous events:
  - clear with a compare in the same cycle: clear wins and the compare is discarded.
  - clear with exp_valid: push discarded; state IDLE.
- Counters saturate at 2^CNT_WIDTH−1; the push counter saturates identically.
- Reset asserted mid-stream aborts immediately. There is no partial-result retention.
- Combinational outputs (pass, busy, done) are derived from registered state only.

Test Plan:
- Matching stream, PIPE_LATENCY=3: push 5 vectors with range 0x8000,0x7F00,0x9000,0xA000,0xB000, last on the 5th. Drive identical dut values 3 cycles later → done 3 cycles after the last push; vec_count=5, err_count=0, pass=1, err_pulse never high.
- Single range error: as above but dut_range=0x7F01 on vector idx 1 → one err_pulse with err_range_flag=1 and err_low_flag=0; first_err_idx=1, err_count=1, pass=0.
- Low masking: vector idx 2 with check_low_en=0 and dut_low off by 1 → no error. Repeat with check_low_en=1 → err_low_flag=1, err_count=1.
- Bubbles and latency: PIPE_LATENCY=5, exp_valid pattern 1,0,0,1,1(last) → exactly 3 compares at push edges +5; vec_count=3; garbage dut values in bubble slots cause no error.
- Clear and reset mid-stream: after 2 pushes, assert clear in the same cycle as a pending mismatching compare → counters 0, state IDLE, no err_pulse. Separately, assert reset asynchronously mid-RUN → all outputs 0 immediately.
- Saturation: CNT_WIDTH=3, push 10 all-mismatching vectors → vec_count=7, err_count=7, first_err_idx=0.
